// File: rtl/krnl_partialknn_mem_pkg.sv
// Shared definitions for the partialKnn banked URAM scratch buffer:
// width helpers, clear-FSM encoding and read-during-write mode constants.
package krnl_partialknn_mem_pkg;

    // Ceiling log2 for elaboration-time width derivation; clog2(1) = 0.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

    // Index width inside one bank.
    function automatic int calc_bw(input int bank_depth);
        return clog2(bank_depth);
    endfunction

    // Bank-select width; a single bank still gets one select bit.
    function automatic int calc_bkw(input int num_banks);
        return (clog2(num_banks) < 1) ? 1 : clog2(num_banks);
    endfunction

    // Full address width {bank, index}.
    function automatic int calc_aw(input int bank_depth, input int num_banks);
        return calc_bw(bank_depth) + calc_bkw(num_banks);
    endfunction

    // Clear controller states.
    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } clr_state_e;

    // Same-address read+write behaviour.
    localparam int RDW_READ_OLD    = 0;
    localparam int RDW_WRITE_FIRST = 1;

endpackage

// File: rtl/krnl_partialknn_uram_bank.sv
// One 1R1W byte-enable URAM bank. The array read is combinational and is
// followed by READ_LATENCY-1 register stages; the parent adds the final
// registered output-mux stage so the total read latency is READ_LATENCY.
module krnl_partialknn_uram_bank
    import krnl_partialknn_mem_pkg::*;
#(
    parameter int DATA_WIDTH   = 256,
    parameter int BANK_DEPTH   = 2048,
    parameter int READ_LATENCY = 2,
    parameter int RDW_MODE     = RDW_READ_OLD,
    localparam int BW          = calc_bw(BANK_DEPTH),
    localparam int BE          = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_wr_en,
    input  logic [BW-1:0]         i_wr_addr,
    input  logic [DATA_WIDTH-1:0] i_wr_data,
    input  logic [BE-1:0]         i_wr_be,
    input  logic [BW-1:0]         i_rd_addr,
    output logic [DATA_WIDTH-1:0] o_rd_data
);

    logic [DATA_WIDTH-1:0] r_mem [BANK_DEPTH];
    logic [DATA_WIDTH-1:0] w_rd_raw;
    logic [DATA_WIDTH-1:0] w_rd_word;

    // Byte-masked array write.
    // NOTE: the storage array has no reset branch -- URAM contents cannot be
    // reset in one cycle; zeroing is done by the parent's clear sequence.
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            for (int b = 0; b < BE; b++) begin
                if (i_wr_be[b]) begin
                    r_mem[i_wr_addr][8*b +: 8] <= i_wr_data[8*b +: 8];
                end
            end
        end
    end

    assign w_rd_raw = r_mem[i_rd_addr];

    // Collision handling: the array always returns the old word; in
    // write-first mode the enabled bytes of a same-address write are merged in.
    // NOTE: combinational blocks use blocking '=' and assign every output a
    // default first, so no latch is inferred for paths that skip the if.
    always_comb begin
        w_rd_word = w_rd_raw;
        if ((RDW_MODE == RDW_WRITE_FIRST) && i_wr_en && (i_wr_addr == i_rd_addr)) begin
            for (int b = 0; b < BE; b++) begin
                if (i_wr_be[b]) begin
                    w_rd_word[8*b +: 8] = i_wr_data[8*b +: 8];
                end
            end
        end
    end

    if (READ_LATENCY == 1) begin : g_comb
        assign o_rd_data = w_rd_word;
    end else begin : g_pipe
        logic [DATA_WIDTH-1:0] r_pipe [READ_LATENCY-1];

        // Read-data delay line; shifts every cycle, validity is tracked upstream.
        // NOTE: sequential state uses non-blocking '<=' so every stage samples
        // the value its predecessor held before this edge.
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                for (int i = 0; i < READ_LATENCY - 1; i++) begin
                    r_pipe[i] <= '0;
                end
            end else begin
                r_pipe[0] <= w_rd_word;
                for (int i = 1; i < READ_LATENCY - 1; i++) begin
                    r_pipe[i] <= r_pipe[i-1];
                end
            end
        end

        assign o_rd_data = r_pipe[READ_LATENCY-2];
    end

endmodule

// File: rtl/krnl_partialknn_uram_banked_buf.sv
// Banked 1R1W scratch buffer for partialKnn: address decode, hardware clear
// FSM, valid/bank-select pipeline and the registered output mux.
module krnl_partialknn_uram_banked_buf
    import krnl_partialknn_mem_pkg::*;
#(
    parameter int DATA_WIDTH     = 256,
    parameter int BANK_DEPTH     = 2048,
    parameter int NUM_BANKS      = 4,
    parameter int READ_LATENCY   = 2,
    parameter int RDW_MODE       = RDW_READ_OLD,
    parameter int CLEAR_ON_RESET = 1,
    localparam int BW            = calc_bw(BANK_DEPTH),
    localparam int BKW           = calc_bkw(NUM_BANKS),
    localparam int AW            = calc_aw(BANK_DEPTH, NUM_BANKS),
    localparam int BE            = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [AW-1:0]         wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [BE-1:0]         wr_be,
    input  logic                  rd_en,
    input  logic [AW-1:0]         rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    input  logic                  clear_req,
    output logic                  clear_busy
);

    localparam logic [BKW:0] NB_LIM   = NUM_BANKS[BKW:0];
    localparam logic [BW-1:0] IDX_LAST = BW'(BANK_DEPTH - 1);

    clr_state_e r_state;
    clr_state_e w_state_nxt;
    logic [BW-1:0] r_clr_cnt;

    logic          w_clearing;
    logic          w_idle;
    logic [BKW-1:0] w_wr_bank;
    logic [BKW-1:0] w_rd_bank;
    logic          w_wr_acc;
    logic          w_rd_acc;
    logic          w_rd_oor;

    logic [BW-1:0]         w_bk_waddr;
    logic [DATA_WIDTH-1:0] w_bk_wdata;
    logic [BE-1:0]         w_bk_wbe;
    logic [NUM_BANKS-1:0]  w_bk_we;
    logic [DATA_WIDTH-1:0] w_bk_rdata [NUM_BANKS];

    logic                  w_fin_vld;
    logic [BKW-1:0]        w_fin_bank;
    logic                  w_fin_oor;
    logic [DATA_WIDTH-1:0] w_mux_data;

    logic                  r_rd_valid;
    logic [DATA_WIDTH-1:0] r_rd_data;

    // Clear FSM state register; reset lands in CLEAR when auto-clear is enabled.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Clear FSM next state: one pass over every index, clear_req only heard in IDLE.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (clear_req) w_state_nxt = ST_CLEAR;
            ST_CLEAR: if (r_clr_cnt == IDX_LAST) w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // Clear index; wraps back to 0 on the last clear cycle (depth is a power of two).
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_clr_cnt <= '0;
        end else if (r_state == ST_CLEAR) begin
            r_clr_cnt <= r_clr_cnt + BW'(1);
        end
    end

    assign w_clearing = (r_state == ST_CLEAR);
    assign w_idle     = (r_state == ST_IDLE);
    assign clear_busy = w_clearing;

    // User accesses are only accepted in IDLE; out-of-range writes are dropped
    // and out-of-range reads are flagged so they still return a zero word in order.
    assign w_wr_bank = wr_addr[AW-1:BW];
    assign w_rd_bank = rd_addr[AW-1:BW];
    assign w_wr_acc  = w_idle && wr_en && ({1'b0, w_wr_bank} < NB_LIM);
    assign w_rd_acc  = w_idle && rd_en;
    assign w_rd_oor  = ({1'b0, w_rd_bank} >= NB_LIM);

    // The clear sequence borrows the write port of every bank at once.
    assign w_bk_waddr = w_clearing ? r_clr_cnt : wr_addr[BW-1:0];
    assign w_bk_wdata = w_clearing ? '0 : wr_data;
    assign w_bk_wbe   = w_clearing ? '1 : wr_be;

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        assign w_bk_we[b] = w_clearing || (w_wr_acc && (w_wr_bank == BKW'(b)));

        krnl_partialknn_uram_bank #(
            .DATA_WIDTH   (DATA_WIDTH),
            .BANK_DEPTH   (BANK_DEPTH),
            .READ_LATENCY (READ_LATENCY),
            .RDW_MODE     (RDW_MODE)
        ) u_bank (
            .clk       (clk),
            .reset     (reset),
            .i_wr_en   (w_bk_we[b]),
            .i_wr_addr (w_bk_waddr),
            .i_wr_data (w_bk_wdata),
            .i_wr_be   (w_bk_wbe),
            .i_rd_addr (rd_addr[BW-1:0]),
            .o_rd_data (w_bk_rdata[b])
        );
    end

    if (READ_LATENCY == 1) begin : g_ctl_direct
        assign w_fin_vld  = w_rd_acc;
        assign w_fin_bank = w_rd_bank;
        assign w_fin_oor  = w_rd_oor;
    end else begin : g_ctl_pipe
        logic [READ_LATENCY-2:0] r_vld;
        logic [READ_LATENCY-2:0] r_oor;
        logic [BKW-1:0]          r_bank [READ_LATENCY-1];

        // Valid, bank select and out-of-range flag travel alongside bank data.
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                r_vld <= '0;
                r_oor <= '0;
                for (int i = 0; i < READ_LATENCY - 1; i++) begin
                    r_bank[i] <= '0;
                end
            end else begin
                r_vld[0]  <= w_rd_acc;
                r_oor[0]  <= w_rd_oor;
                r_bank[0] <= w_rd_bank;
                for (int i = 1; i < READ_LATENCY - 1; i++) begin
                    r_vld[i]  <= r_vld[i-1];
                    r_oor[i]  <= r_oor[i-1];
                    r_bank[i] <= r_bank[i-1];
                end
            end
        end

        assign w_fin_vld  = r_vld[READ_LATENCY-2];
        assign w_fin_bank = r_bank[READ_LATENCY-2];
        assign w_fin_oor  = r_oor[READ_LATENCY-2];
    end

    // Bank select for the final stage; out-of-range reads yield zero.
    always_comb begin
        w_mux_data = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            if (w_fin_bank == BKW'(b)) begin
                w_mux_data = w_bk_rdata[b];
            end
        end
        if (w_fin_oor) begin
            w_mux_data = '0;
        end
    end

    // Registered output stage; rd_data only moves when a read completes.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rd_valid <= 1'b0;
            r_rd_data  <= '0;
        end else begin
            r_rd_valid <= w_fin_vld;
            if (w_fin_vld) begin
                r_rd_data <= w_mux_data;
            end
        end
    end

    assign rd_valid = r_rd_valid;
    assign rd_data  = r_rd_data;

endmodule

// File: tb/tb_krnl_partialknn_uram_banked_buf.sv
// Self-checking bench: three buffer configurations share one stimulus stream;
// a reference model predicts each read and a negedge monitor scores outputs.
module tb_krnl_partialknn_uram_banked_buf;

    localparam int DW    = 256;
    localparam int DEPTH = 2048;
    localparam int BW    = 11;
    localparam int AW    = 13;
    localparam int BE    = DW / 8;
    localparam int NI    = 3;
    localparam int SBD   = 64;

    // Per-instance configuration as seen by the model.
    int nb_m  [NI] = '{3, 4, 4};
    int lat_m [NI] = '{2, 4, 1};
    int rdw_m [NI] = '{0, 1, 0};

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          wr_en = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [DW-1:0] wr_data = '0;
    logic [BE-1:0] wr_be = '0;
    logic          rd_en = 1'b0;
    logic [AW-1:0] rd_addr = '0;
    logic          clear_req = 1'b0;

    logic [DW-1:0] rd_data    [NI];
    logic          rd_valid   [NI];
    logic          clear_busy [NI];

    krnl_partialknn_uram_banked_buf #(
        .DATA_WIDTH(DW), .BANK_DEPTH(DEPTH), .NUM_BANKS(3),
        .READ_LATENCY(2), .RDW_MODE(0), .CLEAR_ON_RESET(1)
    ) u_dut0 (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .wr_be(wr_be), .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data(rd_data[0]), .rd_valid(rd_valid[0]),
        .clear_req(clear_req), .clear_busy(clear_busy[0])
    );

    krnl_partialknn_uram_banked_buf #(
        .DATA_WIDTH(DW), .BANK_DEPTH(DEPTH), .NUM_BANKS(4),
        .READ_LATENCY(4), .RDW_MODE(1), .CLEAR_ON_RESET(1)
    ) u_dut1 (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .wr_be(wr_be), .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data(rd_data[1]), .rd_valid(rd_valid[1]),
        .clear_req(clear_req), .clear_busy(clear_busy[1])
    );

    krnl_partialknn_uram_banked_buf #(
        .DATA_WIDTH(DW), .BANK_DEPTH(DEPTH), .NUM_BANKS(4),
        .READ_LATENCY(1), .RDW_MODE(0), .CLEAR_ON_RESET(1)
    ) u_dut2 (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .wr_be(wr_be), .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data(rd_data[2]), .rd_valid(rd_valid[2]),
        .clear_req(clear_req), .clear_busy(clear_busy[2])
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Model state: memory contents (absent key = zero), remaining busy cycles,
    // scoreboard ring of expected {data, cycle} per instance, last read data.
    logic [DW-1:0] mdl [int];
    int            busy_left = DEPTH;
    logic [DW-1:0] sb_d [NI][SBD];
    int            sb_c [NI][SBD];
    int            sb_head [NI] = '{0, 0, 0};
    int            sb_tail [NI] = '{0, 0, 0};
    logic [DW-1:0] last_d [NI] = '{'0, '0, '0};

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input int inst, input logic ok,
                         input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_cmp++;
        if (!ok) begin
            n_err++;
            $display("FAIL %s [dut%0d] @cyc %0d: got %h expected %h", name, inst, cyc, act, exp);
        end
    endtask

    function automatic int mkey(input int inst, input logic [AW-1:0] a);
        return inst * 65536 + int'(a);
    endfunction

    function automatic logic [DW-1:0] mdl_rd(input int inst, input logic [AW-1:0] a);
        int k;
        k = mkey(inst, a);
        return mdl.exists(k) ? mdl[k] : '0;
    endfunction

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] old_w, input logic [DW-1:0] new_w,
                                            input logic [BE-1:0] be);
        logic [DW-1:0] r;
        r = old_w;
        for (int b = 0; b < BE; b++) if (be[b]) r[8*b +: 8] = new_w[8*b +: 8];
        return r;
    endfunction

    function automatic logic [DW-1:0] rand_word();
        logic [DW-1:0] r;
        for (int i = 0; i < DW / 32; i++) r[32*i +: 32] = $urandom();
        return r;
    endfunction

    function automatic logic [AW-1:0] rand_addr();
        logic [1:0]    bk;
        logic [BW-1:0] ix;
        bk = 2'($urandom_range(0, 3));
        ix = ($urandom_range(0, 3) == 0) ? BW'($urandom_range(0, DEPTH - 1)) : BW'($urandom_range(0, 7));
        return {bk, ix};
    endfunction

    // One clock of stimulus, entered and left just after a rising edge.
    task automatic drive(input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                         input logic [BE-1:0] wbe, input logic re, input logic [AW-1:0] ra,
                         input logic cr);
        wr_en = we; wr_addr = wa; wr_data = wd; wr_be = wbe;
        rd_en = re; rd_addr = ra; clear_req = cr;
        if (busy_left == 0) begin
            for (int i = 0; i < NI; i++) begin
                logic [DW-1:0] rv;
                int            rb;
                int            wb;
                rb = int'(ra[AW-1:BW]);
                wb = int'(wa[AW-1:BW]);
                if (re) begin
                    if (rb >= nb_m[i]) rv = '0;
                    else begin
                        rv = mdl_rd(i, ra);
                        if (rdw_m[i] == 1 && we && wa == ra) rv = merge(rv, wd, wbe);
                    end
                    sb_d[i][sb_tail[i] % SBD] = rv;
                    sb_c[i][sb_tail[i] % SBD] = cyc + lat_m[i];
                    sb_tail[i]++;
                end
                if (we && wb < nb_m[i]) mdl[mkey(i, wa)] = merge(mdl_rd(i, wa), wd, wbe);
            end
        end
        @(posedge clk);
        if (busy_left > 0) busy_left--;
        else if (cr) begin
            busy_left = DEPTH;
            mdl.delete();
        end
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, '0, '0, '0, 1'b0, '0, 1'b0);
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [BE-1:0] be);
        drive(1'b1, a, d, be, 1'b0, '0, 1'b0);
    endtask

    task automatic rd(input logic [AW-1:0] a);
        drive(1'b0, '0, '0, '0, 1'b1, a, 1'b0);
    endtask

    // Hold reset for n edges; everything in flight is forgotten.
    task automatic do_reset(input int n);
        reset = 1'b0;
        wr_en = 1'b0; rd_en = 1'b0; clear_req = 1'b0; wr_be = '0;
        for (int i = 0; i < NI; i++) begin
            sb_head[i] = sb_tail[i];
            last_d[i]  = '0;
        end
        mdl.delete();
        busy_left = DEPTH;
        repeat (n) @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    // Monitor: busy flag every cycle, each rd_valid against the scoreboard
    // head (data and exact cycle), data hold between reads, missed reads.
    always @(negedge clk) begin
        for (int i = 0; i < NI; i++) begin
            logic exp_busy;
            exp_busy = (busy_left > 0);
            check("clear_busy", i, clear_busy[i] === exp_busy, DW'(clear_busy[i]), DW'(exp_busy));
            if (rd_valid[i] === 1'b1) begin
                if (sb_head[i] == sb_tail[i]) begin
                    check("spurious_rd_valid", i, 1'b0, DW'(1), DW'(0));
                end else begin
                    logic [DW-1:0] ed;
                    int            ec;
                    ed = sb_d[i][sb_head[i] % SBD];
                    ec = sb_c[i][sb_head[i] % SBD];
                    sb_head[i]++;
                    check("rd_latency", i, ec == cyc, DW'(cyc), DW'(ec));
                    check("rd_data", i, rd_data[i] === ed, rd_data[i], ed);
                    last_d[i] = ed;
                end
            end else begin
                check("rd_data_hold", i, rd_data[i] === last_d[i], rd_data[i], last_d[i]);
                if (sb_head[i] != sb_tail[i] && sb_c[i][sb_head[i] % SBD] <= cyc) begin
                    check("missing_rd_valid", i, 1'b0, DW'(0), DW'(1));
                    sb_head[i]++;
                end
            end
        end
    end

    initial begin
        // Power-up reset, then the automatic clear runs out.
        do_reset(3);
        while (busy_left > 0) idle(1);
        rd(13'h1FFF);
        idle(5);

        // Byte-enable merge.
        wr(13'h0805, {BE{8'hA5}}, '1);
        wr(13'h0805, DW'(8'h3C), BE'(1));
        wr(13'h0805, rand_word(), '0);
        rd(13'h0805);
        idle(5);

        // Same-address read+write in one cycle.
        wr(13'h0010, {BE{8'h22}}, '1);
        drive(1'b1, 13'h0010, {BE{8'h11}}, '1, 1'b1, 13'h0010, 1'b0);
        rd(13'h0010);
        wr(13'h0010, {BE{8'h44}}, '1);
        drive(1'b1, 13'h0010, {BE{8'h55}}, BE'(32'h0000_FF0F), 1'b1, 13'h0010, 1'b0);
        idle(5);

        // Bank 3: out of range for the 3-bank build, a real bank elsewhere.
        wr(13'h0000, {BE{8'h01}}, '1);
        wr(13'h0800, {BE{8'h02}}, '1);
        wr(13'h1000, {BE{8'h03}}, '1);
        wr(13'h1800, DW'(7), '1);
        rd(13'h1800);
        rd(13'h0000);
        rd(13'h0800);
        rd(13'h1000);
        idle(5);

        // Populate, then 64 back-to-back reads across all banks.
        for (int n = 0; n < 48; n++) wr(rand_addr(), rand_word(), BE'(rand_word()));
        for (int n = 0; n < 64; n++) rd(rand_addr());
        idle(6);

        // Random mix with frequent same-address collisions.
        for (int n = 0; n < 300; n++) begin
            logic [AW-1:0] wa;
            logic [AW-1:0] ra;
            logic [BE-1:0] be;
            wa = rand_addr();
            ra = ($urandom_range(0, 2) == 0) ? wa : rand_addr();
            case ($urandom_range(0, 3))
                0:       be = '0;
                1:       be = '1;
                default: be = BE'(rand_word());
            endcase
            drive(1'($urandom_range(0, 1)), wa, rand_word(), be, 1'($urandom_range(0, 1)), ra, 1'b0);
        end
        idle(6);

        // Reset with reads in flight: nothing may come out afterwards.
        rd(13'h0805);
        rd(13'h0010);
        do_reset(3);
        while (busy_left > 0) idle(1);
        idle(4);

        // Software clear: a read in the request cycle keeps its pre-clear data;
        // accesses and further requests during the clear are ignored.
        wr(13'h0123, rand_word(), '1);
        drive(1'b0, '0, '0, '0, 1'b1, 13'h0123, 1'b1);
        while (busy_left > 0) begin
            drive(1'($urandom_range(0, 1)), rand_addr(), rand_word(), '1,
                  1'($urandom_range(0, 1)), rand_addr(), 1'($urandom_range(0, 1)));
        end
        rd(13'h0123);
        rd(13'h0805);
        idle(8);

        for (int i = 0; i < NI; i++) begin
            check("drain", i, sb_head[i] == sb_tail[i], DW'(sb_tail[i] - sb_head[i]), DW'(0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
